id_ex_pipe: RTL and testbench

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/hazard_fwd_unit.sv | 101 ++++++++++
 rtl/id_ex_pipe.sv | 137 +++++++++++++
 tb/tb_id_ex_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU datapath widths, opcode encoding and forwarding-select type
package cpu_pkg;

   localparam int DATA_W = 16;
   localparam int REG_AW = 4;

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0,
      OP_SUB  = 4'h1,
      OP_NAND = 4'h2,
      OP_XOR  = 4'h3,
      OP_SLL  = 4'h4,
      OP_SRL  = 4'h5,
      OP_SRA  = 4'h6,
      OP_RL   = 4'h7,
      OP_LW   = 4'h8,
      OP_SW   = 4'h9,
      OP_LHB  = 4'hA,
      OP_LLB  = 4'hB,
      OP_B    = 4'hC,
      OP_JAL  = 4'hD,
      OP_JR   = 4'hE,
      OP_HLT  = 4'hF
   } opcode_t;

   typedef enum logic [1:0] {
      FWD_NONE = 2'd0,
      FWD_EX   = 2'd1,
      FWD_MEM  = 2'd2
   } fwd_sel_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - combinational RAW detection, operand selection and stall request
// ID_EX_FWD_EN selects forwarding from EX/MEM; otherwise every RAW match stalls.
module hazard_fwd_unit
   import cpu_pkg::*;
#(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int REG_AW = cpu_pkg::REG_AW
) (
   input  logic              i_id_valid,
   input  logic              i_flush,
   input  logic [REG_AW-1:0] i_rs,
   input  logic [REG_AW-1:0] i_rt,
   input  logic              i_uses_rs,
   input  logic              i_uses_rt,
   input  logic [DATA_W-1:0] i_src1,
   input  logic [DATA_W-1:0] i_src2,
   input  logic              i_ex_valid,
   input  logic              i_ex_regwrite,
   input  logic              i_ex_memread,
   input  logic [REG_AW-1:0] i_ex_rd,
   input  logic [DATA_W-1:0] i_ex_result,
   input  logic              i_mem_valid,
   input  logic              i_mem_regwrite,
   input  logic [REG_AW-1:0] i_mem_rd,
   input  logic [DATA_W-1:0] i_mem_data,
   output logic [DATA_W-1:0] o_op1,
   output logic [DATA_W-1:0] o_op2,
   output logic              o_hazard_stall
);

   // R0 is hard-wired zero, so a producer targeting it is never a dependency.
   function automatic logic producer_match(input logic              valid,
                                           input logic              regwrite,
                                           input logic [REG_AW-1:0] rd,
                                           input logic [REG_AW-1:0] r);
      return valid & regwrite & (rd == r) & (rd != '0);
   endfunction

   logic w_ex_m1;
   logic w_ex_m2;
   logic w_mem_m1;
   logic w_mem_m2;
   logic w_hazard;

   assign w_ex_m1  = i_uses_rs & producer_match(i_ex_valid, i_ex_regwrite, i_ex_rd, i_rs);
   assign w_ex_m2  = i_uses_rt & producer_match(i_ex_valid, i_ex_regwrite, i_ex_rd, i_rt);
   assign w_mem_m1 = i_uses_rs & producer_match(i_mem_valid, i_mem_regwrite, i_mem_rd, i_rs);
   assign w_mem_m2 = i_uses_rt & producer_match(i_mem_valid, i_mem_regwrite, i_mem_rd, i_rt);

`ifdef ID_EX_FWD_EN
   function automatic logic [DATA_W-1:0] fwd_pick(input fwd_sel_t          sel,
                                                  input logic [DATA_W-1:0] rf,
                                                  input logic [DATA_W-1:0] exr,
                                                  input logic [DATA_W-1:0] memd);
      case (sel)
         FWD_EX:  return exr;
         FWD_MEM: return memd;
         default: return rf;
      endcase
   endfunction

   fwd_sel_t w_sel1;
   fwd_sel_t w_sel2;
   logic     w_lu1;
   logic     w_lu2;

   // Load data is not available until MEM, so a load in EX can only be waited on.
   assign w_lu1 = i_uses_rs & i_ex_valid & i_ex_memread & (i_ex_rd == i_rs) & (i_ex_rd != '0);
   assign w_lu2 = i_uses_rt & i_ex_valid & i_ex_memread & (i_ex_rd == i_rt) & (i_ex_rd != '0);

   always_comb begin
      w_sel1 = FWD_NONE;
      w_sel2 = FWD_NONE;
      if (w_ex_m1 && !i_ex_memread) begin
         w_sel1 = FWD_EX;
      end else if (w_mem_m1) begin
         w_sel1 = FWD_MEM;
      end
      if (w_ex_m2 && !i_ex_memread) begin
         w_sel2 = FWD_EX;
      end else if (w_mem_m2) begin
         w_sel2 = FWD_MEM;
      end
   end

   assign o_op1    = fwd_pick(w_sel1, i_src1, i_ex_result, i_mem_data);
   assign o_op2    = fwd_pick(w_sel2, i_src2, i_ex_result, i_mem_data);
   assign w_hazard = w_lu1 | w_lu2;
`else
   logic w_unused_fwd;

   // Without bypass paths the consumer waits until the producer has left MEM.
   assign o_op1        = i_src1;
   assign o_op2        = i_src2;
   assign w_hazard     = w_ex_m1 | w_ex_m2 | w_mem_m1 | w_mem_m2;
   assign w_unused_fwd = ^{i_ex_result, i_mem_data, i_ex_memread};
`endif

   assign o_hazard_stall = w_hazard & i_id_valid & ~i_flush;

endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with bubble insertion and stall counter
// ID_EX_FWD_EN enables EX/MEM operand forwarding in the hazard unit.
module id_ex_pipe
   import cpu_pkg::*;
#(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int REG_AW = cpu_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [DATA_W-1:0] id_src1,
   input  logic [DATA_W-1:0] id_src2,
   input  logic [7:0]        id_imm,
   input  logic [3:0]        id_opcode,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_memwrite,
   input  logic [DATA_W-1:0] ex_result,
   input  logic              mem_valid,
   input  logic              mem_regwrite,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              flush,
   input  logic              stall_in,
   output logic              ex_valid,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic [REG_AW-1:0] ex_rd,
   output logic [3:0]        ex_opcode,
   output logic [7:0]        ex_imm,
   output logic [DATA_W-1:0] ex_op1,
   output logic [DATA_W-1:0] ex_op2,
   output logic              hazard_stall,
   output logic              id_ready,
   output logic [15:0]       stall_cycles
);

   logic              r_ex_valid;
   logic              r_ex_regwrite;
   logic              r_ex_memread;
   logic              r_ex_memwrite;
   logic [REG_AW-1:0] r_ex_rd;
   logic [3:0]        r_ex_opcode;
   logic [7:0]        r_ex_imm;
   logic [DATA_W-1:0] r_ex_op1;
   logic [DATA_W-1:0] r_ex_op2;
   logic [15:0]       r_stall_cycles;

   logic [DATA_W-1:0] w_op1;
   logic [DATA_W-1:0] w_op2;
   logic              w_hazard_stall;

   hazard_fwd_unit #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_hazard_fwd (
      .i_id_valid     (id_valid),
      .i_flush        (flush),
      .i_rs           (id_rs),
      .i_rt           (id_rt),
      .i_uses_rs      (id_uses_rs),
      .i_uses_rt      (id_uses_rt),
      .i_src1         (id_src1),
      .i_src2         (id_src2),
      .i_ex_valid     (r_ex_valid),
      .i_ex_regwrite  (r_ex_regwrite),
      .i_ex_memread   (r_ex_memread),
      .i_ex_rd        (r_ex_rd),
      .i_ex_result    (ex_result),
      .i_mem_valid    (mem_valid),
      .i_mem_regwrite (mem_regwrite),
      .i_mem_rd       (mem_rd),
      .i_mem_data     (mem_data),
      .o_op1          (w_op1),
      .o_op2          (w_op2),
      .o_hazard_stall (w_hazard_stall)
   );

   // Flush only kills the valid bit; the other fields are don't-care once invalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex_valid     <= 1'b0;
         r_ex_regwrite  <= 1'b0;
         r_ex_memread   <= 1'b0;
         r_ex_memwrite  <= 1'b0;
         r_ex_rd        <= '0;
         r_ex_opcode    <= '0;
         r_ex_imm       <= '0;
         r_ex_op1       <= '0;
         r_ex_op2       <= '0;
         r_stall_cycles <= '0;
      end else if (flush) begin
         r_ex_valid <= 1'b0;
      end else if (!stall_in) begin
         if (w_hazard_stall) begin
            r_ex_valid    <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_memwrite <= 1'b0;
            if (r_stall_cycles != 16'hFFFF) begin
               r_stall_cycles <= r_stall_cycles + 16'd1;
            end
         end else begin
            r_ex_valid    <= id_valid;
            r_ex_regwrite <= id_valid & id_regwrite;
            r_ex_memread  <= id_valid & id_memread;
            r_ex_memwrite <= id_valid & id_memwrite;
            r_ex_rd       <= id_rd;
            r_ex_opcode   <= id_opcode;
            r_ex_imm      <= id_imm;
            r_ex_op1      <= w_op1;
            r_ex_op2      <= w_op2;
         end
      end
   end

   assign ex_valid     = r_ex_valid;
   assign ex_regwrite  = r_ex_regwrite;
   assign ex_memread   = r_ex_memread;
   assign ex_memwrite  = r_ex_memwrite;
   assign ex_rd        = r_ex_rd;
   assign ex_opcode    = r_ex_opcode;
   assign ex_imm       = r_ex_imm;
   assign ex_op1       = r_ex_op1;
   assign ex_op2       = r_ex_op2;
   assign stall_cycles = r_stall_cycles;
   assign hazard_stall = w_hazard_stall;
   assign id_ready     = ~w_hazard_stall & ~stall_in;

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - directed scoreboard bench for id_ex_pipe
// ID_EX_FWD_EN selects the forwarding or the stall-only expectations.
module tb_id_ex_pipe;
   import cpu_pkg::*;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [3:0]  id_rs, id_rt, id_rd;
   logic        id_uses_rs, id_uses_rt;
   logic [15:0] id_src1, id_src2;
   logic [7:0]  id_imm;
   logic [3:0]  id_opcode;
   logic        id_regwrite, id_memread, id_memwrite;
   logic [15:0] ex_result;
   logic        mem_valid, mem_regwrite;
   logic [3:0]  mem_rd;
   logic [15:0] mem_data;
   logic        flush, stall_in;
   logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite;
   logic [3:0]  ex_rd;
   logic [3:0]  ex_opcode;
   logic [7:0]  ex_imm;
   logic [15:0] ex_op1, ex_op2;
   logic        hazard_stall, id_ready;
   logic [15:0] stall_cycles;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_sc = 16'd0;

   typedef struct {
      string       tag;
      logic        v;
      logic        rw;
      logic        mr;
      logic [3:0]  rd;
      logic [15:0] op1;
      logic [15:0] op2;
      logic [7:0]  imm;
      logic [15:0] sc;
   } exp_t;

   exp_t sb[$];

   id_ex_pipe dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rd        (id_rd),
      .id_uses_rs   (id_uses_rs),
      .id_uses_rt   (id_uses_rt),
      .id_src1      (id_src1),
      .id_src2      (id_src2),
      .id_imm       (id_imm),
      .id_opcode    (id_opcode),
      .id_regwrite  (id_regwrite),
      .id_memread   (id_memread),
      .id_memwrite  (id_memwrite),
      .ex_result    (ex_result),
      .mem_valid    (mem_valid),
      .mem_regwrite (mem_regwrite),
      .mem_rd       (mem_rd),
      .mem_data     (mem_data),
      .flush        (flush),
      .stall_in     (stall_in),
      .ex_valid     (ex_valid),
      .ex_regwrite  (ex_regwrite),
      .ex_memread   (ex_memread),
      .ex_memwrite  (ex_memwrite),
      .ex_rd        (ex_rd),
      .ex_opcode    (ex_opcode),
      .ex_imm       (ex_imm),
      .ex_op1       (ex_op1),
      .ex_op2       (ex_op2),
      .hazard_stall (hazard_stall),
      .id_ready     (id_ready),
      .stall_cycles (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic set_id(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                         input logic urs, input logic urt,
                         input logic [15:0] s1, input logic [15:0] s2,
                         input logic [3:0] rd, input logic rw, input logic mr,
                         input logic mw, input logic [7:0] imm);
      id_valid    = v;
      id_rs       = rs;
      id_rt       = rt;
      id_uses_rs  = urs;
      id_uses_rt  = urt;
      id_src1     = s1;
      id_src2     = s2;
      id_rd       = rd;
      id_regwrite = rw;
      id_memread  = mr;
      id_memwrite = mw;
      id_imm      = imm;
      id_opcode   = mr ? OP_LW : OP_ADD;
   endtask

   task automatic set_mem(input logic v, input logic [3:0] rd, input logic [15:0] d);
      mem_valid    = v;
      mem_regwrite = v;
      mem_rd       = rd;
      mem_data     = d;
   endtask

   task automatic chk_haz(input string tag, input logic expv);
      #1;
      chk({tag, ".hazard_stall"}, {31'd0, hazard_stall}, {31'd0, expv});
      chk({tag, ".id_ready"}, {31'd0, id_ready}, {31'd0, ~expv & ~stall_in});
   endtask

   task automatic tick(input string tag, input logic v, input logic rw, input logic mr,
                       input logic [3:0] rd, input logic [15:0] op1, input logic [15:0] op2,
                       input logic [7:0] imm);
      exp_t e;
      e.tag = tag; e.v = v; e.rw = rw; e.mr = mr; e.rd = rd;
      e.op1 = op1; e.op2 = op2; e.imm = imm; e.sc = exp_sc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({e.tag, ".ex_valid"},     {31'd0, ex_valid},    {31'd0, e.v});
      chk({e.tag, ".ex_regwrite"},  {31'd0, ex_regwrite}, {31'd0, e.rw});
      chk({e.tag, ".ex_memread"},   {31'd0, ex_memread},  {31'd0, e.mr});
      chk({e.tag, ".ex_rd"},        {28'd0, ex_rd},       {28'd0, e.rd});
      chk({e.tag, ".ex_op1"},       {16'd0, ex_op1},      {16'd0, e.op1});
      chk({e.tag, ".ex_op2"},       {16'd0, ex_op2},      {16'd0, e.op2});
      chk({e.tag, ".ex_imm"},       {24'd0, ex_imm},      {24'd0, e.imm});
      chk({e.tag, ".stall_cycles"}, {16'd0, stall_cycles},{16'd0, e.sc});
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; stall_in = 1'b0; ex_result = 16'h0000;
      set_id(0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 8'h00);
      set_mem(0, 0, 16'h0);

      tick("reset", 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 8'h00);
      rst = 1'b0;

      set_id(1, 2, 3, 1, 1, 16'h00A5, 16'hC130, 5, 1, 0, 0, 8'h12);
      chk_haz("capture", 0);
      tick("capture", 1, 1, 0, 4'd5, 16'h00A5, 16'hC130, 8'h12);

      set_id(1, 5, 8, 0, 0, 16'h1234, 16'h5678, 0, 1, 0, 0, 8'h23);
      chk_haz("unused_src", 0);
      tick("unused_src", 1, 1, 0, 4'd0, 16'h1234, 16'h5678, 8'h23);

      ex_result = 16'hFFFF;
      set_mem(1, 0, 16'hFFFF);
      set_id(1, 0, 0, 1, 1, 16'h0000, 16'h0000, 6, 1, 1, 0, 8'h34);
      chk_haz("r0", 0);
      tick("r0", 1, 1, 1, 4'd6, 16'h0000, 16'h0000, 8'h34);

      set_mem(0, 0, 16'h0);
      flush = 1'b1;
      set_id(1, 6, 0, 1, 0, 16'h7777, 16'h0000, 9, 1, 0, 0, 8'h45);
      chk_haz("flush", 0);
      tick("flush", 0, 1, 1, 4'd6, 16'h0000, 16'h0000, 8'h34);
      flush = 1'b0;

      set_id(1, 0, 0, 0, 0, 16'h0100, 16'h0000, 3, 1, 1, 0, 8'h56);
      chk_haz("load", 0);
      tick("load", 1, 1, 1, 4'd3, 16'h0100, 16'h0000, 8'h56);

      set_id(1, 9, 3, 1, 1, 16'h4444, 16'h0000, 7, 1, 0, 0, 8'h67);
      chk_haz("load_use", 1);
      exp_sc = 16'd1;
      tick("load_use", 0, 0, 0, 4'd3, 16'h0100, 16'h0000, 8'h56);

      set_mem(1, 3, 16'hBEEF);
`ifdef ID_EX_FWD_EN
      chk_haz("lu_fwd", 0);
      tick("lu_fwd", 1, 1, 0, 4'd7, 16'h4444, 16'hBEEF, 8'h67);
`else
      chk_haz("mem_stall", 1);
      exp_sc = 16'd2;
      tick("mem_stall", 0, 0, 0, 4'd3, 16'h0100, 16'h0000, 8'h56);
      set_mem(0, 0, 16'h0);
      set_id(1, 9, 3, 1, 1, 16'h4444, 16'hBEEF, 7, 1, 0, 0, 8'h67);
      chk_haz("mem_done", 0);
      tick("mem_done", 1, 1, 0, 4'd7, 16'h4444, 16'hBEEF, 8'h67);
`endif
      set_mem(0, 0, 16'h0);

      stall_in = 1'b1;
      set_id(1, 1, 2, 1, 1, 16'hAAAA, 16'hBBBB, 8, 1, 0, 1, 8'h78);
      chk_haz("stall_in", 0);
      for (int i = 0; i < 3; i++) begin
         tick("stall_in", 1, 1, 0, 4'd7, 16'h4444, 16'hBEEF, 8'h67);
      end
      stall_in = 1'b0;

`ifdef ID_EX_FWD_EN
      set_id(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 2, 1, 0, 0, 8'h89);
      chk_haz("producer", 0);
      tick("producer", 1, 1, 0, 4'd2, 16'h0000, 16'h0000, 8'h89);
      ex_result = 16'h2570;
      set_mem(1, 2, 16'h1111);
      set_id(1, 2, 0, 1, 0, 16'h0BAD, 16'h0000, 8, 1, 0, 0, 8'h9A);
      chk_haz("ex_fwd", 0);
      tick("ex_fwd", 1, 1, 0, 4'd8, 16'h2570, 16'h0000, 8'h9A);
`else
      set_id(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 4, 1, 0, 0, 8'h89);
      chk_haz("producer", 0);
      tick("producer", 1, 1, 0, 4'd4, 16'h0000, 16'h0000, 8'h89);
      ex_result = 16'h2570;
      set_id(1, 4, 0, 1, 0, 16'h0BAD, 16'h0000, 8, 1, 0, 0, 8'h9A);
      chk_haz("raw_ex", 1);
      exp_sc = 16'd3;
      tick("raw_ex", 0, 0, 0, 4'd4, 16'h0000, 16'h0000, 8'h89);
      set_mem(1, 4, 16'h2570);
      chk_haz("raw_mem", 1);
      exp_sc = 16'd4;
      tick("raw_mem", 0, 0, 0, 4'd4, 16'h0000, 16'h0000, 8'h89);
      set_mem(0, 0, 16'h0);
      chk_haz("raw_done", 0);
      tick("raw_done", 1, 1, 0, 4'd8, 16'h0BAD, 16'h0000, 8'h9A);
`endif
      set_mem(0, 0, 16'h0);

      set_id(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 5, 1, 1, 0, 8'hAB);
      chk_haz("load5", 0);
      tick("load5", 1, 1, 1, 4'd5, 16'h0000, 16'h0000, 8'hAB);
      set_id(1, 5, 0, 1, 0, 16'h0C0C, 16'h0000, 9, 1, 0, 0, 8'hBC);
      rst = 1'b1;
      chk_haz("rst_mid", 1);
      exp_sc = 16'd0;
      tick("rst_mid", 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 8'h00);
      rst = 1'b0;
      chk_haz("post_rst", 0);
      tick("post_rst", 1, 1, 0, 4'd9, 16'h0C0C, 16'h0000, 8'hBC);

      ex_result = 16'h0D0D;
      set_id(0, 9, 0, 1, 0, 16'h0D0D, 16'h0000, 10, 1, 0, 0, 8'hCD);
      chk_haz("invalid_id", 0);
      tick("invalid_id", 0, 0, 0, 4'd10, 16'h0D0D, 16'h0000, 8'hCD);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
